// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the memory bus arbiter.
// Holds FSM state, port owner and access-mode encodings.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for data accesses.
// Strobes, store replication, load extraction, alignment.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [1:0]  lo,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wrep,
  output logic [31:0] rext,
  output logic        misalign
);

  logic [31:0] rsh;

  assign rsh = rdata >> {lo, 3'b000};

  // Decode mode into lane enables, replicated data, masked load
  always_comb begin
    wstrb    = 4'b0000;
    wrep     = wdata;
    rext     = 32'h0;
    misalign = 1'b0;
    unique case (1'b1)
      (mode == MODE_BYTE): begin
        wstrb = 4'b0001 << lo;
        wrep  = {4{wdata[7:0]}};
        rext  = {24'h0, rsh[7:0]};
      end
      (mode == MODE_HALF): begin
        wstrb    = 4'b0011 << lo;
        wrep     = {2{wdata[15:0]}};
        rext     = {16'h0, rsh[15:0]};
        misalign = lo[0];
      end
      (mode == MODE_WORD): begin
        wstrb    = 4'b1111;
        rext     = rsh;
        misalign = |lo;
      end
      default: misalign = 1'b1;
    endcase
    if (!wen) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between I and D ports.
// Data-first arbitration with a bounded fetch starvation window.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ok,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [1:0]  d_mode,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ok,
  output logic        d_misalign,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t state;
  state_t state_nx;
  owner_t owner_q;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [1:0]    mode_q;
  logic          wen_q;
  logic [CW-1:0] starve_cnt;

  logic idle;
  logic arb_en;
  logic grant_i;
  logic grant_d;
  logic mis_grant;
  logic bus_grant;
  logic complete;

  logic [1:0]  al_mode;
  logic [1:0]  al_lo;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wrep;
  logic [31:0] al_rext;
  logic        al_mis;

  assign idle = (state == IDLE);

  // The ok-pulse cycle is dead: the owner still holds req.
  assign arb_en = idle && !i_ok && !d_ok;

  assign grant_i = arb_en && i_req &&
                   (!d_req || starve_cnt == LIMIT);
  assign grant_d = arb_en && d_req && !grant_i;

  assign mis_grant = grant_d && al_mis;
  assign bus_grant = grant_i || (grant_d && !al_mis);

  assign complete = bus_data_ok &&
                    ((state == ADDR && bus_addr_ok) ||
                     state == DATA);

  // Aligner sees the incoming request in IDLE, the latched one after.
  assign al_mode = idle ? d_mode : mode_q;
  assign al_lo   = idle ? d_addr[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .mode     (al_mode),
    .lo       (al_lo),
    .wen      (d_wen),
    .wdata    (d_wdata),
    .rdata    (bus_rdata),
    .wstrb    (al_wstrb),
    .wrep     (al_wrep),
    .rext     (al_rext),
    .misalign (al_mis)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus_grant) state_nx = ADDR;
      ADDR: begin
        if (bus_addr_ok)
          state_nx = bus_data_ok ? IDLE : DATA;
      end
      DATA: if (bus_data_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs: driven only while a transaction is live
  always_comb begin
    bus_req   = (state == ADDR);
    bus_wr    = 1'b0;
    bus_addr  = 32'h0;
    bus_wstrb = 4'b0000;
    bus_wdata = 32'h0;
    if (!idle) begin
      bus_wr    = wen_q;
      bus_addr  = addr_q;
      bus_wstrb = wstrb_q;
      bus_wdata = wdata_q;
    end
  end

  // Latch the granted request for the whole transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= OWN_I;
      addr_q  <= 32'h0;
      mode_q  <= MODE_WORD;
      wen_q   <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
    end else if (bus_grant) begin
      owner_q <= grant_i ? OWN_I : OWN_D;
      addr_q  <= grant_i ? i_addr : d_addr;
      mode_q  <= grant_i ? MODE_WORD : d_mode;
      wen_q   <= !grant_i && d_wen;
      wstrb_q <= grant_i ? 4'b0000 : al_wstrb;
      wdata_q <= (!grant_i && d_wen) ? al_wrep : 32'h0;
    end
  end

  // Count data wins while a fetch waits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Completion pulses and returned data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_ok       <= 1'b0;
      d_ok       <= 1'b0;
      d_misalign <= 1'b0;
      i_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
    end else begin
      i_ok       <= complete && owner_q == OWN_I;
      d_ok       <= (complete && owner_q == OWN_D) ||
                    mis_grant;
      d_misalign <= mis_grant;
      if (complete && owner_q == OWN_I)
        i_rdata <= bus_rdata;
      if (complete && owner_q == OWN_D)
        d_rdata <= wen_q ? 32'h0 : al_rext;
      else if (mis_grant)
        d_rdata <= 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter.
// Bus responder, result/bus monitors, per-scenario tasks.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_rdata;
  logic        i_ok;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [1:0]  d_mode = 2'b11;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ok;
  logic        d_misalign;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  typedef struct {
    bit          is_i;
    bit          mis;
    bit          chk_rd;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } bexp_t;

  exp_t  exp_q[$];
  bexp_t bus_q[$];

  int checks = 0;
  int errors = 0;

  int          addr_lat = 0;
  int          data_lat = 0;
  bit          same_cycle = 1'b0;
  logic [31:0] rd_val = 32'h0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ok        (i_ok),
    .d_req       (d_req),
    .d_wen       (d_wen),
    .d_mode      (d_mode),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ok        (d_ok),
    .d_misalign  (d_misalign),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  function automatic int m_bytes(input logic [1:0] m);
    if (m == 2'b00) return 1;
    if (m == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] m,
                                        input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    for (int k = 0; k < m_bytes(m); k++) s[int'(a) + k] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_rep(input logic [1:0] m,
                                        input logic [31:0] wd);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = wd[8*(k % m_bytes(m)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd,
                                         input logic [1:0] m,
                                         input logic [1:0] a);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < m_bytes(m); k++)
      r[8*k +: 8] = rd[8*(int'(a) + k) +: 8];
    return r;
  endfunction

  // Bus slave: drives handshakes just after each rising edge
  initial begin
    int  acnt;
    int  dcnt;
    bit  pend;
    acnt = 0;
    dcnt = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
        acnt = 0;
      end else if (bus_req) begin
        if (acnt < addr_lat) begin
          acnt++;
        end else begin
          acnt = 0;
          bus_addr_ok = 1'b1;
          if (same_cycle) begin
            bus_data_ok = 1'b1;
            bus_rdata   = rd_val;
          end else begin
            pend = 1'b1;
            dcnt = 0;
          end
        end
      end else if (pend) begin
        if (dcnt < data_lat) begin
          dcnt++;
        end else begin
          bus_data_ok = 1'b1;
          bus_rdata   = rd_val;
          pend        = 1'b0;
        end
      end
    end
  end

  // Scoreboard and bus-side monitor
  initial begin
    exp_t  e;
    bexp_t b;
    bit    prev_dok;
    bit    prev_ok;
    bit    prev_breq;
    bit    prev_aok;
    prev_dok  = 1'b0;
    prev_ok   = 1'b0;
    prev_breq = 1'b0;
    prev_aok  = 1'b0;
    forever begin
      @(negedge clk);
      if (i_ok === 1'b1 || d_ok === 1'b1) begin
        checks++;
        if (i_ok === 1'b1 && d_ok === 1'b1) begin
          errors++;
          $display("FAIL ok_exclusive i_ok=%b d_ok=%b need one",
                   i_ok, d_ok);
        end
        checks++;
        if (prev_ok) begin
          errors++;
          $display("FAIL ok_width ok high two cycles, need one");
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ok i_ok=%b d_ok=%b none expected",
                   i_ok, d_ok);
        end else begin
          e = exp_q.pop_front();
          if (i_ok !== e.is_i) begin
            errors++;
            $display("FAIL owner got i_ok=%b need %b", i_ok, e.is_i);
          end else if (d_misalign !== e.mis) begin
            errors++;
            $display("FAIL misalign_flag got %b need %b",
                     d_misalign, e.mis);
          end else if (e.chk_rd &&
                       (e.is_i ? i_rdata : d_rdata) !== e.rdata) begin
            errors++;
            $display("FAIL rdata got %h need %h",
                     e.is_i ? i_rdata : d_rdata, e.rdata);
          end
          if (!e.mis) begin
            checks++;
            if (!prev_dok) begin
              errors++;
              $display("FAIL ok_latency data_ok prev=%b need 1",
                       prev_dok);
            end
          end
        end
      end
      if (bus_req === 1'b1 && bus_addr_ok === 1'b1) begin
        checks++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bus addr=%h", bus_addr);
        end else begin
          b = bus_q.pop_front();
          if ({bus_wr, bus_addr, bus_wstrb, bus_wdata} !==
              {b.wr, b.addr, b.strb, b.wdata}) begin
            errors++;
            $display("FAIL bus_fields got %b %h %b %h need %b %h %b %h",
                     bus_wr, bus_addr, bus_wstrb, bus_wdata,
                     b.wr, b.addr, b.strb, b.wdata);
          end
        end
      end
      if (resetn && prev_breq && !prev_aok) begin
        checks++;
        if (bus_req !== 1'b1) begin
          errors++;
          $display("FAIL req_hold bus_req=%b need 1 before addr_ok",
                   bus_req);
        end
      end
      prev_dok  = bus_data_ok;
      prev_ok   = i_ok | d_ok;
      prev_breq = bus_req;
      prev_aok  = bus_addr_ok;
    end
  end

  task automatic d_access(input logic [31:0] a, input logic [1:0] m,
                          input bit w, input logic [31:0] wd,
                          input logic [31:0] rd);
    exp_t  e;
    bexp_t b;
    bit    mis;
    bit    done;
    mis = (m == 2'b10) || (m == 2'b01 && a[0]) ||
          (m == 2'b11 && a[1:0] != 2'b00);
    e.is_i   = 1'b0;
    e.mis    = mis;
    e.chk_rd = !mis && !w;
    e.rdata  = mis ? 32'h0 : m_load(rd, m, a[1:0]);
    exp_q.push_back(e);
    if (!mis) begin
      b.wr    = w;
      b.addr  = a;
      b.strb  = w ? m_strb(m, a[1:0]) : 4'b0000;
      b.wdata = w ? m_rep(m, wd) : 32'h0;
      bus_q.push_back(b);
    end
    @(negedge clk);
    rd_val  = rd;
    d_addr  = a;
    d_mode  = m;
    d_wen   = w;
    d_wdata = wd;
    d_req   = 1'b1;
    done    = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (mis) begin
          if ({d_ok, d_misalign, bus_req} !== 3'b110) begin
            errors++;
            $display("FAIL misalign_timing ok/mis/req=%b%b%b need 110",
                     d_ok, d_misalign, bus_req);
          end
        end else if (bus_req !== 1'b1) begin
          errors++;
          $display("FAIL req_latency bus_req=%b need 1", bus_req);
        end
      end
      if (d_ok === 1'b1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL d_timeout addr=%h no d_ok", a);
    end
    d_req = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] a, input logic [31:0] rd);
    exp_t  e;
    bexp_t b;
    bit    done;
    e.is_i   = 1'b1;
    e.mis    = 1'b0;
    e.chk_rd = 1'b1;
    e.rdata  = rd;
    exp_q.push_back(e);
    b.wr    = 1'b0;
    b.addr  = a;
    b.strb  = 4'b0000;
    b.wdata = 32'h0;
    bus_q.push_back(b);
    @(negedge clk);
    rd_val = rd;
    i_addr = a;
    i_req  = 1'b1;
    done   = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (bus_req !== 1'b1) begin
          errors++;
          $display("FAIL i_req_latency bus_req=%b need 1", bus_req);
        end
      end
      if (i_ok === 1'b1) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL i_timeout addr=%h no i_ok", a);
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
         i_ok, d_ok, d_misalign, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs req=%b strb=%b addr=%h ok=%b%b",
               bus_req, bus_wstrb, bus_addr, i_ok, d_ok);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_req, i_ok, d_ok, bus_addr} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle req=%b ok=%b%b addr=%h need 0",
               bus_req, i_ok, d_ok, bus_addr);
    end
  endtask

  task automatic test_byte_store();
    data_lat = 1;
    d_access(32'h0000_1003, 2'b00, 1'b1, 32'h0000_00AB, 32'h0);
    data_lat = 0;
  endtask

  task automatic test_half_load();
    d_access(32'h0000_2002, 2'b01, 1'b0, 32'h0, 32'h1234_ABCD);
  endtask

  task automatic test_lanes();
    logic [31:0] tbl_a[12];
    logic [1:0]  tbl_m[12];
    bit          tbl_w[12];
    tbl_a = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h22,
              32'h30, 32'h41, 32'h42, 32'h50, 32'h52, 32'h60};
    tbl_m = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01,
              2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11};
    tbl_w = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    for (int k = 0; k < 12; k++) begin
      addr_lat = k % 3;
      data_lat = (k / 3) % 3;
      d_access(tbl_a[k], tbl_m[k], tbl_w[k], $urandom(), $urandom());
    end
    addr_lat = 0;
    data_lat = 0;
  endtask

  task automatic test_misalign();
    d_access(32'h0000_3001, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF);
    d_access(32'h0000_3002, 2'b11, 1'b1, 32'h1, 32'h0);
    d_access(32'h0000_2001, 2'b01, 1'b0, 32'h0, 32'h0);
    d_access(32'h0000_0000, 2'b10, 1'b0, 32'h0, 32'h0);
    d_access(32'h0000_3004, 2'b11, 1'b0, 32'h0, 32'h5A5A_0F0F);
  endtask

  task automatic test_fetch();
    i_access(32'h0000_0100, 32'hDEAD_BEEF);
    addr_lat = 2;
    i_access(32'h0000_0104, 32'h0BAD_F00D);
    addr_lat = 0;
  endtask

  task automatic test_same_cycle();
    same_cycle = 1'b1;
    d_access(32'h0000_7001, 2'b00, 1'b0, 32'h0, 32'h00C3_0000);
    i_access(32'h0000_0200, 32'h1357_9BDF);
    same_cycle = 1'b0;
  endtask

  task automatic test_starvation();
    exp_t  e;
    bexp_t b;
    int    dcnt;
    bit    seen_i;
    bit    done;
    for (int k = 0; k < 6; k++) begin
      e.is_i   = (k == 4);
      e.mis    = 1'b0;
      e.chk_rd = 1'b1;
      e.rdata  = 32'hCAFE_0001;
      exp_q.push_back(e);
      b.wr    = 1'b0;
      b.addr  = (k == 4) ? 32'h0000_0300 : 32'h0000_4000;
      b.strb  = 4'b0000;
      b.wdata = 32'h0;
      bus_q.push_back(b);
    end
    @(negedge clk);
    rd_val = 32'hCAFE_0001;
    i_addr = 32'h0000_0300;
    d_addr = 32'h0000_4000;
    d_mode = 2'b11;
    d_wen  = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    dcnt   = 0;
    seen_i = 1'b0;
    done   = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (d_ok === 1'b1) begin
        dcnt++;
        if (seen_i) begin
          d_req = 1'b0;
          done  = 1'b1;
        end
      end
      if (i_ok === 1'b1) begin
        checks++;
        if (dcnt !== 4) begin
          errors++;
          $display("FAIL starve_grants got %0d D grants need 4", dcnt);
        end
        seen_i = 1'b1;
        i_req  = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout dcnt=%0d seen_i=%b", dcnt, seen_i);
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t  e;
    bexp_t b;
    bit    hs;
    e.is_i   = 1'b0;
    e.mis    = 1'b0;
    e.chk_rd = 1'b1;
    e.rdata  = 32'h8765_4321;
    exp_q.push_back(e);
    b.wr    = 1'b0;
    b.addr  = 32'h0000_5000;
    b.strb  = 4'b0000;
    b.wdata = 32'h0;
    bus_q.push_back(b);
    data_lat = 50;
    @(negedge clk);
    rd_val = 32'h8765_4321;
    d_addr = 32'h0000_5000;
    d_mode = 2'b11;
    d_wen  = 1'b0;
    d_req  = 1'b1;
    hs     = 1'b0;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      if (bus_req === 1'b1 && bus_addr_ok === 1'b1) hs = 1'b1;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL mid_handshake no address handshake seen");
    end
    @(negedge clk);
    #2;
    resetn = 1'b0;
    d_req  = 1'b0;
    #1;
    checks++;
    if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
         i_ok, d_ok, d_misalign, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs addr=%h ok=%b%b need 0",
               bus_addr, i_ok, d_ok);
    end
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    data_lat = 0;
    repeat (3) @(negedge clk);
    d_access(32'h0000_5004, 2'b11, 1'b0, 32'h0, 32'h2468_ACE0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_byte_store();
    test_half_load();
    test_lanes();
    test_misalign();
    test_fetch();
    test_same_cycle();
    test_starvation();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus_q.size() != 0) begin
      errors++;
      $display("FAIL leftover exp=%0d bus=%0d need 0 0",
               exp_q.size(), bus_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, the maximum number of consecutive data grants while an instruction request waits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock; rising edge.
- resetn  in  1  asynchronous, active-low reset.
REQ-003 Instruction-port ports SHALL be:
- i_req  in  1  fetch request; held until i_ok.
- i_addr  in  32  word fetch address.
- i_rdata  out  32  fetched word.
- i_ok  out  1  one-cycle completion pulse.
REQ-004 Data-port ports SHALL be:
- d_req  in  1  load/store request; held until d_ok.
- d_wen  in  1  1 = store.
- d_mode  in  2  00 byte, 01 half, 11 word; 10 is illegal.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, low-aligned.
- d_rdata  out  32  load data shifted to bit 0; upper bits zero (the Memory stage extends it).
- d_ok  out  1  one-cycle completion pulse.
- d_misalign  out  1  pulses with d_ok when the request was rejected.
REQ-005 Downstream bus ports SHALL be:
- bus_req  out  1  transaction request.
- bus_wr  out  1  write.
- bus_addr  out  32  byte address.
- bus_wstrb  out  4  byte enables; 0000 on reads.
- bus_wdata  out  32  lane-replicated store data.
- bus_addr_ok  in  1  address accepted.
- bus_data_ok  in  1  data phase complete.
- bus_rdata  in  32  read word.

Function
REQ-006 The FSM SHALL have three states: IDLE, ADDR (bus_req high, all bus_* outputs stable) and DATA (waiting for bus_data_ok).
REQ-007 In IDLE, a legal pending request SHALL latch owner, address, mode, wen and wdata, and enter ADDR on the next edge, so bus_req rises one cycle after the request is sampled.
REQ-008 Arbitration SHALL favour the data port, except that I wins when i_req is pending and starve_cnt == STARVE_LIMIT.
REQ-009 starve_cnt SHALL be handled as follows: +1 on each D grant while i_req is high, cleared on an I grant or when i_req is low, saturating at STARVE_LIMIT.
REQ-010 ADDR SHALL move to DATA when bus_addr_ok=1. If bus_addr_ok and bus_data_ok are both 1 in the same cycle, it SHALL complete directly and return to IDLE.
REQ-011 DATA SHALL return to IDLE when bus_data_ok=1. The owner's ok SHALL pulse exactly one cycle, registered one cycle after bus_data_ok, with rdata valid in that same cycle.
REQ-012 Byte enables SHALL be: byte = 0001<<a[1:0]; half = 0011<<a[1:0]; word = 1111.
REQ-013 Store data SHALL be replicated as follows: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-014 Load data SHALL be: d_rdata = bus_rdata >> (8*a[1:0]), masked to 8/16/32 bits by mode.
REQ-015 A data request is misaligned when any of these hold: half with a[0]=1, word with a[1:0]!=0, or mode 10. Such a request SHALL produce d_ok=d_misalign=1 for one cycle one cycle after sampling, issue no bus transaction, and stay in IDLE.
REQ-016 Instruction fetches SHALL always be word reads (wstrb 0000).
REQ-017 Requests arriving while not in IDLE SHALL wait, and no second transaction SHALL be outstanding.
REQ-018 i_ok and d_ok SHALL never be high in the same cycle.
REQ-019 Once bus_req is high, it SHALL NOT drop before bus_addr_ok.

Reset
REQ-020 When resetn=0, asynchronously: state=IDLE, starve_cnt=0, and every output 0 (bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, i_ok, d_ok, d_misalign, i_rdata, d_rdata).
REQ-021 Reset mid-transaction SHALL abandon the transaction without an ok pulse; downstream recovery is the bus's responsibility.

Structure
REQ-022 Package mem_bus_pkg SHALL hold the state enum (IDLE/ADDR/DATA), the owner enum (OWN_I/OWN_D) and the mode constants MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b11.
REQ-023 A combinational sub-module mem_lane_align SHALL compute wstrb, replicated wdata, shifted/masked rdata and the misalign flag. The FSM, counter and registers SHALL stay in the top module.

Verification
REQ-024 Byte store: d_mode=00, d_addr=0x1003, d_wdata=0xAB -> bus_wstrb=1000, bus_wdata=0xABABABAB, bus_wr=1, d_ok one cycle after bus_data_ok.
REQ-025 Half load: addr=0x2002, bus_rdata=0x1234ABCD -> d_rdata=0x00001234.
REQ-026 Misalign: word at 0x3001 -> d_ok=d_misalign=1 one cycle later, bus_req stays 0.
REQ-027 Starvation: i_req held while d_req is re-asserted continuously -> I granted after exactly 4 D grants.
REQ-028 Same-cycle bus_addr_ok and bus_data_ok -> ADDR goes to IDLE, ok pulses once.
REQ-029 resetn low while in DATA -> outputs 0 immediately, no ok pulse, next request starts a clean transaction.
